// File: rtl/axis_packet_gen.sv
// AXI-Stream test packet source. It emits NUM_PKTS packets of PKT_LEN beats
// each. The destination rotates from packet to packet and the payload is
// deterministic: {packet index, beat index}. Packets are separated by
// GAP_CYCLES idle cycles. Every output comes straight from a flop.
module axis_packet_gen #(
  parameter int TDATAW     = 32,
  parameter int TDESTW     = 4,
  parameter int TIDW       = 2,
  parameter int NUM_PKTS   = 8,
  parameter int PKT_LEN    = 4,
  parameter int NUM_DESTS  = 4,
  parameter int DEST_START = 0,
  parameter int SRC_ID     = 0,
  parameter int GAP_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TIDW-1:0]   AXIS_M_TID,
  output logic [TDESTW-1:0] AXIS_M_TDEST
);

  localparam int HALF_W = TDATAW / 2;
  localparam int PKT_W  = (NUM_PKTS > 1)   ? $clog2(NUM_PKTS)   : 1;
  localparam int BEAT_W = (PKT_LEN > 1)    ? $clog2(PKT_LEN)    : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [PKT_W-1:0]  PKT_LAST   = PKT_W'(NUM_PKTS - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(PKT_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TDESTW-1:0] DEST_FIRST = TDESTW'(DEST_START);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t              state_q,    state_d;
  logic [PKT_W-1:0]    pkt_idx_q,  pkt_idx_d;
  logic [BEAT_W-1:0]   beat_idx_q, beat_idx_d;
  logic [GAP_W-1:0]    gap_cnt_q,  gap_cnt_d;
  logic                tvalid_q,   tvalid_d;
  logic                tlast_q,    tlast_d;
  logic [TDATAW-1:0]   tdata_q,    tdata_d;
  logic [TDESTW-1:0]   tdest_q,    tdest_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;

  // Payload word: packet index in the upper half, beat index in the lower
  // half. Each index is zero-extended or truncated to fit its half.
  function automatic logic [TDATAW-1:0] pack_beat(input logic [PKT_W-1:0]  p,
                                                  input logic [BEAT_W-1:0] b);
    return {HALF_W'(p), HALF_W'(b)};
  endfunction

  // Step through NUM_DESTS destinations. The sequence starts at DEST_START
  // and wraps back to it.
  function automatic logic [TDESTW-1:0] next_dest(input logic [TDESTW-1:0] d);
    int off;
    off = (int'(d) - DEST_START + 1) % NUM_DESTS;
    return TDESTW'(off + DEST_START);
  endfunction

  // State, counters and output registers; async reset to the idle values
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      pkt_idx_q  <= '0;
      beat_idx_q <= '0;
      gap_cnt_q  <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      tdest_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_idx_q  <= pkt_idx_d;
      beat_idx_q <= beat_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      tdest_q    <= tdest_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic and next values of the registered outputs. A stalled
  // beat keeps the defaults, so the presented beat holds still.
  always_comb begin
    state_d    = state_q;
    pkt_idx_d  = pkt_idx_q;
    beat_idx_d = beat_idx_q;
    gap_cnt_d  = gap_cnt_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;
    tdest_d    = tdest_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      IDLE, FINISH: begin
        if (START) begin
          state_d    = SEND;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pkt_idx_d  = '0;
          beat_idx_d = '0;
          gap_cnt_d  = '0;
          tdest_d    = DEST_FIRST;
          tvalid_d   = 1'b1;
          tdata_d    = pack_beat('0, '0);
          tlast_d    = (BEAT_LAST == '0);
        end
      end

      SEND: begin
        if (tvalid_q && AXIS_M_TREADY) begin
          if (tlast_q) begin
            pkt_idx_d  = pkt_idx_q + PKT_W'(1);
            beat_idx_d = '0;
            tdest_d    = next_dest(tdest_q);
            if (pkt_idx_q == PKT_LAST) begin
              state_d  = FINISH;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state_d   = GAP;
              tvalid_d  = 1'b0;
              tlast_d   = 1'b0;
              gap_cnt_d = '0;
            end else begin
              tvalid_d = 1'b1;
              tdata_d  = pack_beat(pkt_idx_q + PKT_W'(1), '0);
              tlast_d  = (BEAT_LAST == '0);
            end
          end else begin
            beat_idx_d = beat_idx_q + BEAT_W'(1);
            tdata_d    = pack_beat(pkt_idx_q, beat_idx_q + BEAT_W'(1));
            tlast_d    = ((beat_idx_q + BEAT_W'(1)) == BEAT_LAST);
          end
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = SEND;
          gap_cnt_d = '0;
          tvalid_d  = 1'b1;
          tdata_d   = pack_beat(pkt_idx_q, '0);
          tlast_d   = (BEAT_LAST == '0);
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign AXIS_M_TVALID = tvalid_q;
  assign AXIS_M_TDATA  = tdata_q;
  assign AXIS_M_TLAST  = tlast_q;
  assign AXIS_M_TDEST  = tdest_q;
  assign AXIS_M_TID    = TIDW'(SRC_ID);

endmodule

// File: tb/tb_axis_packet_gen.sv
// Directed bench for axis_packet_gen. It uses three instances:
//   dut0: default parameters, checked beat by beat against a packet scoreboard
//   dut1: GAP_CYCLES=0, PKT_LEN=1, NUM_PKTS=3
//   dut2: NUM_DESTS=3, DEST_START=5, NUM_PKTS=7, PKT_LEN=2, GAP_CYCLES=1, SRC_ID=2
module tb_axis_packet_gen;

  logic clk;
  logic rst_n;

  logic        start0, busy0, done0, tvalid0, tready0, tlast0;
  logic [31:0] tdata0;
  logic [1:0]  tid0;
  logic [3:0]  tdest0;

  logic        start1, busy1, done1, tvalid1, tready1, tlast1;
  logic [31:0] tdata1;
  logic [1:0]  tid1;
  logic [3:0]  tdest1;

  logic        start2, busy2, done2, tvalid2, tready2, tlast2;
  logic [31:0] tdata2;
  logic [1:0]  tid2;
  logic [3:0]  tdest2;

  int n_chk;
  int n_err;

  // Scoreboard state for dut0
  logic        mon_en;
  logic        tog_en;
  logic [31:0] exp_pkt;
  logic [31:0] exp_beat;
  int          sb_beats;
  int          idle_run;
  logic        stall_prev;
  logic        fin_pending;
  logic [31:0] held_data;
  logic        held_last;
  logic [3:0]  held_dest;

  axis_packet_gen dut0 (
    .CLK(clk), .RST_N(rst_n), .START(start0), .BUSY(busy0), .DONE(done0),
    .AXIS_M_TVALID(tvalid0), .AXIS_M_TREADY(tready0), .AXIS_M_TDATA(tdata0),
    .AXIS_M_TLAST(tlast0), .AXIS_M_TID(tid0), .AXIS_M_TDEST(tdest0)
  );

  axis_packet_gen #(.GAP_CYCLES(0), .PKT_LEN(1), .NUM_PKTS(3)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .BUSY(busy1), .DONE(done1),
    .AXIS_M_TVALID(tvalid1), .AXIS_M_TREADY(tready1), .AXIS_M_TDATA(tdata1),
    .AXIS_M_TLAST(tlast1), .AXIS_M_TID(tid1), .AXIS_M_TDEST(tdest1)
  );

  axis_packet_gen #(.NUM_DESTS(3), .DEST_START(5), .NUM_PKTS(7), .PKT_LEN(2),
                    .GAP_CYCLES(1), .SRC_ID(2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start2), .BUSY(busy2), .DONE(done2),
    .AXIS_M_TVALID(tvalid2), .AXIS_M_TREADY(tready2), .AXIS_M_TDATA(tdata2),
    .AXIS_M_TLAST(tlast2), .AXIS_M_TID(tid2), .AXIS_M_TDEST(tdest2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_reset();
    exp_pkt     = 0;
    exp_beat    = 0;
    sb_beats    = 0;
    idle_run    = 0;
    stall_prev  = 1'b0;
    fin_pending = 1'b0;
  endtask

  // Scoreboard for dut0: 8 packets of 4 beats, TDEST = pkt mod 4, gap of 2
  task automatic mon0();
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (fin_pending) begin
          check("done_next", done0, 1);
          check("busy_end", busy0, 0);
          check("vld_end", tvalid0, 0);
          fin_pending = 1'b0;
        end
        if (stall_prev) begin
          check("hold_vld", tvalid0, 1);
          check("hold_data", tdata0, held_data);
          check("hold_last", tlast0, held_last);
          check("hold_dest", tdest0, held_dest);
        end
        stall_prev = 1'b0;
        if (tvalid0) begin
          if (idle_run != 0) check("gap_len", idle_run, 2);
          idle_run = 0;
          if (!tready0) begin
            stall_prev = 1'b1;
            held_data  = tdata0;
            held_last  = tlast0;
            held_dest  = tdest0;
          end else begin
            check("sb_data", tdata0, {exp_pkt[15:0], exp_beat[15:0]});
            check("sb_last", tlast0, (exp_beat == 3));
            check("sb_dest", tdest0, exp_pkt % 4);
            check("sb_tid", tid0, 0);
            sb_beats++;
            if (exp_beat == 3) begin
              exp_beat = 0;
              exp_pkt  = exp_pkt + 1;
              if (exp_pkt == 8) fin_pending = 1'b1;
            end else begin
              exp_beat = exp_beat + 1;
            end
          end
        end else if (busy0) begin
          idle_run++;
        end
      end
    end
  endtask

  // Alternating TREADY for dut0 while tog_en is set
  task automatic toggler();
    forever begin
      @(posedge clk);
      #2;
      if (tog_en) tready0 = ~tready0;
    end
  endtask

  task automatic pulse0();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
  endtask

  task automatic wait_done0(input int lim);
    int n;
    n = 0;
    while (!done0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", done0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int dtab[7];
    int idx;
    int cnt;
    dtab = '{5, 6, 7, 5, 6, 7, 5};
    n_chk = 0; n_err = 0;
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    tready0 = 1'b1; tready1 = 1'b1; tready2 = 1'b1;
    mon_en = 1'b0; tog_en = 1'b0;
    held_data = '0; held_last = 1'b0; held_dest = '0;
    sb_reset();
    fork
      mon0();
      toggler();
    join_none

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", tvalid0, 0);
    check("rst_last", tlast0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_data", tdata0, 0);
    check("rst_dest", tdest0, 0);
    check("rst_tid2", tid2, 2);
    rst_n = 1'b1;

    // Run 1: TREADY high, one START
    sb_reset();
    mon_en = 1'b1;
    @(posedge clk); #1 start0 = 1'b1;
    check("no_comb_start", tvalid0, 0);
    @(posedge clk); #1 start0 = 1'b0;
    check("lat1_vld", tvalid0, 1);
    check("lat1_busy", busy0, 1);
    wait_done0(200);
    check("run1_beats", sb_beats, 32);
    check("run1_busy", busy0, 0);

    // Run 2: START while DONE, alternating TREADY, START again mid-run
    sb_reset();
    tready0 = 1'($urandom_range(0, 1));
    tog_en  = 1'b1;
    pulse0();
    check("restart_done", done0, 0);
    check("restart_busy", busy0, 1);
    repeat (20) @(posedge clk);
    pulse0();
    check("midstart_busy", busy0, 1);
    check("midstart_done", done0, 0);
    wait_done0(400);
    check("run2_beats", sb_beats, 32);
    tog_en  = 1'b0;
    tready0 = 1'b1;

    // Run 3: reset asserted on beat 2 of packet 3
    sb_reset();
    pulse0();
    cnt = 0;
    while (!(exp_pkt == 2 && exp_beat == 1) && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    mon_en = 1'b0;
    check("pre_rst_data", tdata0, 32'h0002_0001);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld", tvalid0, 0);
    check("arst_last", tlast0, 0);
    check("arst_data", tdata0, 0);
    check("arst_dest", tdest0, 0);
    check("arst_busy", busy0, 0);
    check("arst_tid", tid0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (tvalid0) cnt++;
    end
    check("idle_no_beat", cnt, 0);
    check("idle_done", done0, 0);
    sb_reset();
    @(posedge clk); #1;
    mon_en = 1'b1;
    pulse0();
    wait_done0(200);
    check("run3_beats", sb_beats, 32);
    mon_en = 1'b0;

    // dut1: single-beat packets, no gap
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("d1_vld", tvalid1, 1);
      check("d1_last", tlast1, 1);
      check("d1_data", tdata1, 32'(k) << 16);
    end
    @(negedge clk);
    check("d1_end_vld", tvalid1, 0);
    check("d1_done", done1, 1);

    // dut2: destination rotation 5,6,7,5,...
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    idx = 0;
    cnt = 0;
    while (!done2 && cnt < 200) begin
      @(negedge clk);
      if (tvalid2 && tlast2) begin
        if (idx < 7) check("d2_dest", tdest2, dtab[idx]);
        idx++;
      end
      cnt++;
    end
    check("d2_pkts", idx, 7);
    check("d2_done", done2, 1);
    check("d2_tid", tid2, 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
